// File: rtl/checker_arbiter.sv
// checker_arbiter: two-requester round-robin arbiter feeding one trace checker, plus record counters
//   clk, reset (async, active-low)
//   reqN_char/reqN_valid in, reqN_ready out : per-requester character stream
//   chk_char/chk_valid out : accepted character, one cycle after transfer
//   chk_format in : checker verdict driving cnt_reg/cnt_mem
//   grant out : one-hot owner (01 req0, 10 req1, 00 none)
module checker_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req0_char,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_char,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] chk_char,
  output logic       chk_valid,
  input  logic [1:0] chk_format,
  output logic [1:0] grant,
  output logic [7:0] cnt_reg,
  output logic [7:0] cnt_mem
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] idle_q, idle_d;
  logic [7:0] chk_char_q, chk_char_d;
  logic       chk_valid_q, chk_valid_d;
  logic [7:0] cnt_reg_q, cnt_reg_d;
  logic [7:0] cnt_mem_q, cnt_mem_d;
  logic       xfer0, xfer1, xfer, rel;
  logic [7:0] xchar;
  assign xfer0 = state_q == GNT0 && req0_valid;
  assign xfer1 = state_q == GNT1 && req1_valid;
  assign xfer  = xfer0 | xfer1;
  assign xchar = xfer1 ? req1_char : req0_char;
  // '#' ends a record; otherwise a silent cycle at TIMEOUT-1 gives the grant up
  assign rel   = state_q != IDLE && (xfer ? xchar == 8'h23 : idle_q == 8'(TIMEOUT - 1));
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    idle_d      = 8'd0;
    chk_char_d  = xfer ? xchar : chk_char_q;
    chk_valid_d = xfer;
    cnt_reg_d   = (chk_format == 2'b01 && cnt_reg_q != 8'hFF) ? cnt_reg_q + 8'd1 : cnt_reg_q;
    cnt_mem_d   = (chk_format == 2'b10 && cnt_mem_q != 8'hFF) ? cnt_mem_q + 8'd1 : cnt_mem_q;
    if (state_q == IDLE) begin
      // on a tie, last_q=1 means req1 was released last, so req0 wins
      state_d = (req0_valid && (!req1_valid || last_q)) ? GNT0 : req1_valid ? GNT1 : IDLE;
    end else begin
      idle_d = (xfer || rel) ? 8'd0 : idle_q + 8'd1;
      if (rel) begin
        state_d = IDLE;
        last_d  = state_q == GNT1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      idle_q      <= 8'd0;
      chk_char_q  <= 8'h00;
      chk_valid_q <= 1'b0;
      cnt_reg_q   <= 8'd0;
      cnt_mem_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      idle_q      <= idle_d;
      chk_char_q  <= chk_char_d;
      chk_valid_q <= chk_valid_d;
      cnt_reg_q   <= cnt_reg_d;
      cnt_mem_q   <= cnt_mem_d;
    end
  end
  assign grant      = {state_q == GNT1, state_q == GNT0};
  assign req0_ready = state_q == GNT0;
  assign req1_ready = state_q == GNT1;
  assign chk_char   = chk_char_q;
  assign chk_valid  = chk_valid_q;
  assign cnt_reg    = cnt_reg_q;
  assign cnt_mem    = cnt_mem_q;
endmodule

// File: tb/tb_checker_arbiter.sv
// tb_checker_arbiter: directed stimulus with a queue scoreboard on the checker stream
module tb_checker_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] req0_char = 8'h00, req1_char = 8'h00;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] chk_char;
  logic       chk_valid;
  logic [1:0] chk_format = 2'b00;
  logic [1:0] grant;
  logic [7:0] cnt_reg, cnt_mem;
  logic [7:0] exp_q[$];
  logic [7:0] e;
  int         n_pass = 0, n_total = 0;
  string      rec = "^1@00003000: $ 1 <= 00000001#";
  string      s2 = "^12@";

  checker_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req0_char(req0_char), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_char(req1_char), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .chk_char(chk_char), .chk_valid(chk_valid), .chk_format(chk_format),
    .grant(grant), .cnt_reg(cnt_reg), .cnt_mem(cnt_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got chk_valid with chk_char %0h, expected no pulse", chk_char);
      end else begin
        e = exp_q.pop_front();
        chk("sb_char", int'(chk_char), int'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    chk("rst_grant", grant, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_chk_valid", chk_valid, 0);
    chk("rst_chk_char", chk_char, 0);
    chk("rst_cnt_reg", cnt_reg, 0);
    chk("rst_cnt_mem", cnt_mem, 0);
    // both valid constantly: req0 wins first tie, streams its record
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_char = rec[0]; req1_char = "Z";
    #3 reset = 1'b1;
    chk("no_grant_before_edge", grant, 0);
    tick();
    chk("tie_grant0", grant, 1);
    chk("ready0_on", req0_ready, 1);
    chk("ready1_off", req1_ready, 0);
    for (int i = 0; i < rec.len(); i++) begin
      req0_char = rec[i];
      exp_q.push_back(rec[i]);
      tick();
    end
    chk("hash_release", grant, 0);
    tick();
    chk("rr_grant1", grant, 2);
    req0_valid = 1'b0;
    req1_char = "#";
    exp_q.push_back("#");
    tick();
    chk("req1_hash_release", grant, 0);
    req1_valid = 1'b0;
    // req1 alone, then times out; req0 valid meanwhile is ignored
    req1_char = "^"; req1_valid = 1'b1;
    tick();
    chk("solo_grant1", grant, 2);
    for (int i = 0; i < s2.len(); i++) begin
      req1_char = s2[i];
      exp_q.push_back(s2[i]);
      tick();
    end
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_char = "X";
    repeat (15) tick();
    chk("hold_15_idle", grant, 2);
    tick();
    chk("timeout_16", grant, 0);
    req1_valid = 1'b1;
    tick();
    chk("tie_after_timeout", grant, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    // transfer on the TIMEOUT-1 cycle keeps the grant and restarts the count
    repeat (15) tick();
    chk("pause_15", grant, 1);
    req0_valid = 1'b1; req0_char = "A";
    exp_q.push_back("A");
    tick();
    chk("xfer_at_limit_holds", grant, 1);
    req0_valid = 1'b0;
    repeat (15) tick();
    chk("restart_hold", grant, 1);
    tick();
    chk("restart_timeout", grant, 0);
    // record counters
    chk_format = 2'b01;
    repeat (200) tick();
    chk("cnt_reg_200", cnt_reg, 200);
    repeat (100) tick();
    chk("cnt_reg_sat", cnt_reg, 8'hFF);
    chk("cnt_mem_idle", cnt_mem, 0);
    chk_format = 2'b10;
    repeat (3) tick();
    chk("cnt_mem_3", cnt_mem, 3);
    chk("cnt_reg_held", cnt_reg, 8'hFF);
    chk_format = 2'b11;
    repeat (5) tick();
    chk("fmt11_reg", cnt_reg, 8'hFF);
    chk("fmt11_mem", cnt_mem, 3);
    chk_format = 2'b00;
    // async reset mid-record
    req0_valid = 1'b1; req0_char = "a";
    tick();
    chk("mid_grant", grant, 1);
    exp_q.push_back("a");
    tick();
    req0_char = "b";
    exp_q.push_back("b");
    tick();
    req0_char = "c";
    #6 reset = 1'b0;
    #1;
    chk("async_grant", grant, 0);
    chk("async_ready0", req0_ready, 0);
    chk("async_chk_valid", chk_valid, 0);
    chk("async_chk_char", chk_char, 0);
    chk("async_cnt_reg", cnt_reg, 0);
    chk("async_cnt_mem", cnt_mem, 0);
    repeat (2) tick();
    req1_valid = 1'b1;
    #3 reset = 1'b1;
    chk("post_rst_no_grant", grant, 0);
    tick();
    chk("post_rst_tie0", grant, 1);
    req1_valid = 1'b0;
    req0_char = "#";
    exp_q.push_back("#");
    tick();
    chk("post_rst_release", grant, 0);
    req0_valid = 1'b0;
    repeat (3) tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/checker_arbiter.md
CHECKER_ARBITER -- requirements
Module: checker_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the idle cycles within a granted record before the grant is released; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces reset state immediately, independent of clk.
REQ-004 req0_char  input  8  ASCII character from requester 0.
REQ-005 req0_valid  input  1  requester 0 presents a character.
REQ-006 req0_ready  output  1  arbiter accepts req0_char this cycle.
REQ-007 req1_char, req1_valid, req1_ready SHALL mirror REQ-004..006 for requester 1.
REQ-008 chk_char  output  8  registered character driven to the shared trace checker.
REQ-009 chk_valid  output  1  chk_char holds a newly accepted character this cycle.
REQ-010 chk_format  input  2  checker verdict: 00 none, 01 register record, 10 memory record, 11 ignored.
REQ-011 grant  output  2  one-hot owner: 01 requester 0, 10 requester 1, 00 none.
REQ-012 cnt_reg  output  8  completed register-record count.
REQ-013 cnt_mem  output  8  completed memory-record count.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, GNT0, GNT1; grant SHALL be 00/01/10 respectively, decoded from state only.
REQ-015 reqN_ready SHALL be 1 only in GNTN, with no combinational path from any input.
REQ-016 A transfer SHALL occur on a cycle with reqN_valid=1 and reqN_ready=1; no other cycle SHALL consume a character.
REQ-017 Each transfer SHALL set chk_char to the accepted character and chk_valid to 1 on the next edge (latency 1); on cycles with no transfer, chk_valid SHALL be 0 and chk_char SHALL hold its value.
REQ-018 In IDLE with exactly one requester valid, the FSM SHALL move to that requester's GNT state on the next edge.
REQ-019 In IDLE with both requesters valid, the FSM SHALL grant the requester other than the last one released (round-robin pointer "last").
REQ-020 In IDLE with no requester valid, the FSM SHALL remain in IDLE.
REQ-021 In GNTN, a transfer of character "#" (8'h23) SHALL move the FSM to IDLE on the same edge and set last=N.
REQ-022 In GNTN, an idle counter SHALL clear on every transfer and increment on every non-transfer cycle.
REQ-023 When the idle counter reaches TIMEOUT-1 on a non-transfer cycle, the FSM SHALL return to IDLE, set last=N and clear the counter.
REQ-024 A transfer on the TIMEOUT-1 cycle SHALL clear the counter and retain the grant; a transfer of "#" takes precedence over timeout.
REQ-025 The idle counter SHALL be 0 whenever the FSM is in IDLE.
REQ-026 The non-granted requester's valid SHALL have no effect while a grant is held.
REQ-027 Minimum turnaround SHALL be one IDLE cycle between consecutive grants, including grants to the same requester.
REQ-028 Each cycle, chk_format=01 SHALL increment cnt_reg and chk_format=10 SHALL increment cnt_mem by one; 00 and 11 SHALL leave both counters unchanged.
REQ-029 cnt_reg and cnt_mem SHALL saturate at 8'hFF.
REQ-030 The counters SHALL update independently of FSM state, including during IDLE.

Reset
REQ-031 While reset=0, the block SHALL hold: state IDLE, last=1 (requester 0 wins the first tie), idle counter 0, chk_char 8'h00, chk_valid 0, cnt_reg 0, cnt_mem 0, both ready 0, grant 00.
REQ-032 Reset asserted mid-record SHALL abandon the record with no further chk_valid pulse; no state SHALL survive reset.
REQ-033 After reset deasserts, the first grant SHALL occur no earlier than the first rising edge with reset=1.

Verification
REQ-034 Reset deassert, both valid constantly -> grant=01 one edge later; req0 record "^1@00003000: $ 1 <= 00000001#" forwarded byte-for-byte with 1-cycle latency; after "#", one IDLE cycle, then grant=10.
REQ-035 Only req1 valid, sends "^12@", then valid=0 for 16 cycles (TIMEOUT=16) -> grant drops to 00 on the 16th idle cycle; next tie goes to req0.
REQ-036 Granted requester pauses 15 cycles, then sends a character on the 16th -> grant held, counter restarts.
REQ-037 Drive chk_format=01 for 300 cycles, then 10 for 3 cycles -> cnt_reg=8'hFF, cnt_mem=8'h03; format 11 for 5 cycles -> no change.
REQ-038 Assert reset asynchronously mid-record between clock edges -> all outputs reach reset values before the next edge; no chk_valid pulse follows until a new grant.
